// File: rtl/onehot_code_expander.sv
// Expands a strobe-captured 4-bit index code (plus none flag) into a registered 16-bit one-hot vector,
// held (latch mode) or driven for PULSE_LEN cycles (pulse mode). `define STROBE_SYNC_EN adds a 2-flop strobe synchronizer.
module onehot_code_expander #(
   parameter int PULSE_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      PULSE = 2'd2
   } state_t;

   localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);

   logic [3:0]  index;
   logic        none;
   logic        strobe_raw;
   logic        mode;
   logic        clear;

   logic        strobe;
   logic        s3;
   logic        capture;

   logic [15:0] decoded;

   state_t      state;
   state_t      state_next;
   logic [15:0] vec;
   logic [15:0] vec_next;
   logic [7:0]  count;
   logic [7:0]  count_next;

   logic        unused_inputs;

   assign index      = ui_in[3:0];
   assign none       = ui_in[4];
   assign strobe_raw = ui_in[5];
   assign mode       = ui_in[6];
   assign clear      = ui_in[7];

   // Power-good and the bidirectional inputs carry nothing for this block.
   assign unused_inputs = ena ^ (^uio_in);

`ifdef STROBE_SYNC_EN
   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= strobe_raw;
         s2 <= s1;
      end
   end

   assign strobe = s2;
`else
   assign strobe = strobe_raw;
`endif

   // Edge history keeps running through clear so a strobe held across clear cannot re-fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3 <= 1'b0;
      end else begin
         s3 <= strobe;
      end
   end

   assign capture = strobe & ~s3;

   // Index 15 is never produced by the encoder and decodes like "none".
   always_comb begin
      decoded = 16'h0000;
      if (!none && (index != 4'hF)) begin
         decoded[index] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         vec   <= 16'h0000;
         count <= 8'h00;
      end else begin
         state <= state_next;
         vec   <= vec_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      vec_next   = vec;
      count_next = count;

      if (clear) begin
         state_next = IDLE;
         vec_next   = 16'h0000;
         count_next = 8'h00;
      end else if (capture) begin
         vec_next = decoded;
         if (mode) begin
            state_next = PULSE;
            count_next = PULSE_RELOAD;
         end else begin
            state_next = HOLD;
            count_next = 8'h00;
         end
      end else begin
         case (state)
            IDLE: begin
               vec_next = 16'h0000;
            end
            HOLD: begin
               vec_next = vec;
            end
            PULSE: begin
               // Reload is PULSE_LEN-1, so the vector is visible for exactly PULSE_LEN cycles.
               if (count == 8'h00) begin
                  state_next = IDLE;
                  vec_next   = 16'h0000;
               end else begin
                  count_next = count - 8'h01;
               end
            end
            default: begin
               state_next = IDLE;
               vec_next   = 16'h0000;
               count_next = 8'h00;
            end
         endcase
      end
   end

   assign uo_out  = vec[7:0];
   assign uio_out = vec[15:8];
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_onehot_code_expander.sv
// Directed, table-driven bench for onehot_code_expander (PULSE_LEN=4); capture latency follows STROBE_SYNC_EN.
module tb_onehot_code_expander;

`ifdef STROBE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_fail   = 0;

   onehot_code_expander #(.PULSE_LEN(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ui;
      logic [15:0] expv;
      string       name;
   } vec_t;

   vec_t tbl[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 16'h%04h, expected 16'h%04h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check_out(input string name, input logic [15:0] expv);
      check(name, {uio_out, uo_out}, expv);
   endtask

   // Strobe low long enough to clear edge history, then raise it; returns just after the capture edge.
   task automatic do_capture(input logic [7:0] code, input logic [15:0] prev, input string name);
      ui_in = code & 8'hDF;
      repeat (LAT + 2) tick();
      ui_in = code | 8'h20;
      for (int i = 0; i < LAT; i++) begin
         tick();
         check_out({name, "_pre"}, prev);
      end
      tick();
   endtask

   initial begin
      tbl[0] = '{8'h23, 16'h0008, "tbl_idx3"};
      tbl[1] = '{8'h30, 16'h0000, "tbl_none"};
      tbl[2] = '{8'h2F, 16'h0000, "tbl_idx15"};
      tbl[3] = '{8'h20, 16'h0001, "tbl_idx0"};
      tbl[4] = '{8'h2A, 16'h0400, "tbl_idx10"};
      tbl[5] = '{8'h3F, 16'h0000, "tbl_none15"};
      tbl[6] = '{8'h2E, 16'h4000, "tbl_idx14"};

      // Reset
      rst_n = 1'b0;
      ui_in = 8'h00;
      repeat (3) tick();
      check_out("reset_out", 16'h0000);
      check("reset_oe", {8'h00, uio_oe}, 16'h00FF);
      rst_n = 1'b1;
      repeat (2) tick();
      check_out("idle_out", 16'h0000);
      check("idle_oe", {8'h00, uio_oe}, 16'h00FF);

      // Latch mode held 20 cycles, then a new code
      do_capture(8'h2E, 16'h0000, "latch14");
      check_out("latch14", 16'h4000);
      ui_in = 8'h0E;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_out("latch14_hold", 16'h4000);
      end
      do_capture(8'h23, 16'h4000, "latch3");
      check_out("latch3", 16'h0008);

      // Table of latch-mode codes
      for (int i = 0; i < 7; i++) begin
         logic [15:0] prev;
         prev = (i == 0) ? 16'h0008 : tbl[i-1].expv;
         do_capture(tbl[i].ui, prev, tbl[i].name);
         check_out(tbl[i].name, tbl[i].expv);
         ui_in = tbl[i].ui & 8'hDF;
         repeat (3) tick();
         check_out({tbl[i].name, "_hold"}, tbl[i].expv);
      end

      // Strobe held high: only one capture
      do_capture(8'h27, 16'h4000, "held7");
      check_out("held7", 16'h0080);
      ui_in = 8'h29;
      repeat (6) tick();
      check_out("held_no_recapture", 16'h0080);

      // Pulse mode: exactly 4 cycles
      do_capture(8'h65, 16'h0080, "pulse5");
      check_out("pulse5_c1", 16'h0020);
      ui_in = 8'h45;
      for (int i = 2; i <= 4; i++) begin
         tick();
         check_out("pulse5_c", 16'h0020);
      end
      tick();
      check_out("pulse5_end", 16'h0000);
      repeat (5) tick();
      check_out("pulse5_idle", 16'h0000);

      // Re-strobe mid-pulse restarts the count with the new code
      do_capture(8'h65, 16'h0000, "rpulse5");
      check_out("rpulse5_c1", 16'h0020);
      ui_in = 8'h45;
      tick();
      check_out("rpulse5_c2", 16'h0020);
      ui_in = 8'h61;
      for (int i = 0; i <= LAT; i++) begin
         tick();
         check_out("rpulse_switch", (i == LAT) ? 16'h0002 : 16'h0020);
      end
      ui_in = 8'h41;
      repeat (3) tick();
      check_out("rpulse1_c4", 16'h0002);
      tick();
      check_out("rpulse1_end", 16'h0000);

      // Pulse with none code: zero output for the pulse
      do_capture(8'h2B, 16'h0000, "latch11");
      check_out("latch11", 16'h0800);
      do_capture(8'h70, 16'h0800, "pulse_none");
      check_out("pulse_none", 16'h0000);
      repeat (4) tick();
      check_out("pulse_none_after", 16'h0000);

      // Clear wins over a coincident capture
      do_capture(8'h28, 16'h0000, "latch8");
      check_out("latch8", 16'h0100);
      ui_in = 8'h08;
      repeat (LAT + 2) tick();
      ui_in = 8'h22;
      for (int i = 0; i < LAT; i++) begin
         tick();
         check_out("clr_pre", 16'h0100);
      end
      ui_in = 8'hA2;
      tick();
      check_out("clr_wins", 16'h0000);
      ui_in = 8'h22;
      repeat (6) tick();
      check_out("clr_no_idx2", 16'h0000);

      // Async reset mid-pulse
      do_capture(8'h65, 16'h0000, "apulse5");
      check_out("apulse5", 16'h0020);
      #2;
      rst_n = 1'b0;
      ui_in = 8'h00;
      #1;
      check_out("async_rst_now", 16'h0000);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check_out("async_rst_quiet", 16'h0000);

      // Strobe still high across reset release: one capture after the sync latency
      rst_n = 1'b0;
      ui_in = 8'h24;
      repeat (2) tick();
      check_out("rst_strobe_in_rst", 16'h0000);
      rst_n = 1'b1;
      repeat (LAT + 1) tick();
      check_out("rst_strobe_cap", 16'h0010);
      check("final_oe", {8'h00, uio_oe}, 16'h00FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
